// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter state set and the
// parity helper that the receiver will also use.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_ODD  = 2'd1;
   localparam logic [1:0] PAR_EVEN = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   // Even parity is the XOR of the payload; odd is its inverse.
   function automatic logic parity_of(input logic [8:0] data, input logic [1:0] mode);
      parity_of = (mode == PAR_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side ready/valid word handshake plus frame status for uart_tx_param.
interface uart_tx_param_if #(
   parameter int DATA_BITS = 8
) ();

   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;
   logic                 tx_busy;
   logic                 tx_done;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, tx_busy, tx_done
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, tx_busy, tx_done
   );

endinterface

// File: rtl/uart_bit_timer.sv
// Sync-gated tick counter that marks the last tick of each bit cell.
module uart_bit_timer import uart_pkg::*; #(
   parameter int TICKS_PER_BIT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sync,
   input  logic clear,
   output logic cell_end
);

   localparam int            TW   = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(TICKS_PER_BIT - 1);

   logic [TW-1:0] cnt;

   assign cell_end = sync & ~clear & (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (sync) begin
         cnt <= cell_end ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: ready/valid word in, LSB-first serial frame
// out with optional parity and one or two stop bits, paced by the sync tick.
module uart_tx_param import uart_pkg::*; #(
   parameter int DATA_BITS     = 8,
   parameter int TICKS_PER_BIT = 2,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sync,
   output logic            tx_out,
   uart_tx_param_if.slave  bus
);

   localparam logic [2:0] S_IDLE   = uart_pkg::IDLE;
   localparam logic [2:0] S_START  = uart_pkg::START;
   localparam logic [2:0] S_DATA   = uart_pkg::DATA;
   localparam logic [2:0] S_PARITY = uart_pkg::PARITY;
   localparam logic [2:0] S_STOP   = uart_pkg::STOP;

   localparam int            BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   generate
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx_param: PARITY must be 0, 1 or 2");
      end
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx_param: DATA_BITS must be 5..9");
      end
      if (TICKS_PER_BIT < 1 || TICKS_PER_BIT > 16) begin : g_bad_ticks
         $error("uart_tx_param: TICKS_PER_BIT must be 1..16");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
         $error("uart_tx_param: STOP_BITS must be 1 or 2");
      end
   endgenerate

   logic [2:0]           state;
   logic [DATA_BITS-1:0] shreg;
   logic                 par;
   logic [BW-1:0]        bitcnt;
   logic                 cell_end;

   // Holding the timer clear in IDLE keeps a sync on the accept edge out of the start cell.
   uart_bit_timer #(
      .TICKS_PER_BIT(TICKS_PER_BIT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .sync     (sync),
      .clear    (state == S_IDLE),
      .cell_end (cell_end)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         shreg        <= '0;
         par          <= 1'b0;
         bitcnt       <= '0;
         tx_out       <= 1'b1;
         bus.tx_ready <= 1'b1;
         bus.tx_busy  <= 1'b0;
         bus.tx_done  <= 1'b0;
      end else begin
         bus.tx_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.tx_valid && bus.tx_ready) begin
                  shreg        <= bus.tx_data;
                  par          <= parity_of(9'(bus.tx_data), 2'(PARITY));
                  bitcnt       <= '0;
                  state        <= S_START;
                  tx_out       <= 1'b0;
                  bus.tx_ready <= 1'b0;
                  bus.tx_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (cell_end) begin
                  state  <= S_DATA;
                  tx_out <= shreg[0];
                  shreg  <= shreg >> 1;
                  bitcnt <= '0;
               end
            end
            S_DATA: begin
               if (cell_end) begin
                  if (bitcnt == LAST_BIT) begin
                     bitcnt <= '0;
                     if (PARITY != 0) begin
                        state  <= S_PARITY;
                        tx_out <= par;
                     end else begin
                        state  <= S_STOP;
                        tx_out <= 1'b1;
                     end
                  end else begin
                     bitcnt <= bitcnt + 1'b1;
                     tx_out <= shreg[0];
                     shreg  <= shreg >> 1;
                  end
               end
            end
            S_PARITY: begin
               if (cell_end) begin
                  state  <= S_STOP;
                  tx_out <= 1'b1;
               end
            end
            S_STOP: begin
               // bitcnt is reused to count stop cells.
               if (cell_end) begin
                  if (bitcnt == LAST_STOP) begin
                     state        <= S_IDLE;
                     bitcnt       <= '0;
                     bus.tx_done  <= 1'b1;
                     bus.tx_busy  <= 1'b0;
                     bus.tx_ready <= 1'b1;
                  end else begin
                     bitcnt <= bitcnt + 1'b1;
                  end
               end
            end
            default: begin
               state  <= S_IDLE;
               tx_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param across several parameter sets.
module tb_uart_tx_param;

   logic clk = 1'b0;
   logic rst;
   logic sync0, sync1, sync3, sync4;
   logic line0, line1, line2, line3, line4;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   uart_tx_param_if #(.DATA_BITS(8)) if0 ();
   uart_tx_param_if #(.DATA_BITS(8)) if1 ();
   uart_tx_param_if #(.DATA_BITS(8)) if2 ();
   uart_tx_param_if #(.DATA_BITS(7)) if3 ();
   uart_tx_param_if #(.DATA_BITS(8)) if4 ();

   uart_tx_param #(.DATA_BITS(8), .TICKS_PER_BIT(2), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .sync(sync0), .tx_out(line0), .bus(if0.slave));
   uart_tx_param #(.DATA_BITS(8), .TICKS_PER_BIT(2), .PARITY(2), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst(rst), .sync(sync1), .tx_out(line1), .bus(if1.slave));
   uart_tx_param #(.DATA_BITS(8), .TICKS_PER_BIT(2), .PARITY(1), .STOP_BITS(1)) dut2 (
      .clk(clk), .rst(rst), .sync(sync1), .tx_out(line2), .bus(if2.slave));
   uart_tx_param #(.DATA_BITS(7), .TICKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) dut3 (
      .clk(clk), .rst(rst), .sync(sync3), .tx_out(line3), .bus(if3.slave));
   uart_tx_param #(.DATA_BITS(8), .TICKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) dut4 (
      .clk(clk), .rst(rst), .sync(sync4), .tx_out(line4), .bus(if4.slave));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (line0 !== 1'b1 || if0.tx_ready !== 1'b1 || if0.tx_busy !== 1'b0 || if0.tx_done !== 1'b0)
         begin errors++; $display("FAIL reset_state: line=%b ready=%b busy=%b done=%b, want 1 1 0 0",
                                  line0, if0.tx_ready, if0.tx_busy, if0.tx_done); end
      checks++;
      if (line3 !== 1'b1 || if3.tx_ready !== 1'b1 || line4 !== 1'b1)
         begin errors++; $display("FAIL reset_others: line3=%b ready3=%b line4=%b, want 1 1 1",
                                  line3, if3.tx_ready, line4); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_frame_8n1();
      logic [9:0] cells;
      cells = 10'b1101001010;
      if0.tx_data  = 8'hA5;
      if0.tx_valid = 1'b1;
      step();
      if0.tx_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (line0 !== cells[k/2] || if0.tx_busy !== 1'b1 || if0.tx_ready !== 1'b0 || if0.tx_done !== 1'b0)
            begin errors++; $display("FAIL frame_8n1 cycle %0d: line=%b busy=%b ready=%b done=%b, want line=%b busy=1 ready=0 done=0",
                                     k, line0, if0.tx_busy, if0.tx_ready, if0.tx_done, cells[k/2]); end
         step();
      end
      checks++;
      if (if0.tx_done !== 1'b1 || if0.tx_ready !== 1'b1 || if0.tx_busy !== 1'b0 || line0 !== 1'b1)
         begin errors++; $display("FAIL frame_8n1_end: done=%b ready=%b busy=%b line=%b, want 1 1 0 1",
                                  if0.tx_done, if0.tx_ready, if0.tx_busy, line0); end
      step();
      checks++;
      if (if0.tx_done !== 1'b0)
         begin errors++; $display("FAIL frame_8n1_done_width: done=%b, want 0", if0.tx_done); end
   endtask

   task automatic test_parity();
      logic [10:0] even_cells, odd_cells;
      even_cells = 11'b10101001010;
      odd_cells  = 11'b11101001010;
      if1.tx_data = 8'hA5; if1.tx_valid = 1'b1;
      if2.tx_data = 8'hA5; if2.tx_valid = 1'b1;
      step();
      if1.tx_valid = 1'b0;
      if2.tx_valid = 1'b0;
      for (int k = 0; k < 22; k++) begin
         checks++;
         if (line1 !== even_cells[k/2] || if1.tx_done !== 1'b0)
            begin errors++; $display("FAIL parity_even cycle %0d: line=%b done=%b, want line=%b done=0",
                                     k, line1, if1.tx_done, even_cells[k/2]); end
         checks++;
         if (line2 !== odd_cells[k/2] || if2.tx_done !== 1'b0)
            begin errors++; $display("FAIL parity_odd cycle %0d: line=%b done=%b, want line=%b done=0",
                                     k, line2, if2.tx_done, odd_cells[k/2]); end
         step();
      end
      checks++;
      if (if1.tx_done !== 1'b1 || if2.tx_done !== 1'b1 || if1.tx_ready !== 1'b1 || if2.tx_ready !== 1'b1)
         begin errors++; $display("FAIL parity_end: done=%b/%b ready=%b/%b, want 1/1 1/1",
                                  if1.tx_done, if2.tx_done, if1.tx_ready, if2.tx_ready); end
      step();
   endtask

   task automatic test_7bit_2stop();
      logic [9:0] cells;
      cells = 10'b1110000010;
      if3.tx_data  = 7'h41;
      if3.tx_valid = 1'b1;
      sync3 = 1'b1;
      step();
      if3.tx_valid = 1'b0;
      for (int k = 0; k < 120; k++) begin
         checks++;
         if (line3 !== cells[k/12] || if3.tx_busy !== 1'b1 || if3.tx_done !== 1'b0)
            begin errors++; $display("FAIL frame_7n2 cycle %0d: line=%b busy=%b done=%b, want line=%b busy=1 done=0",
                                     k, line3, if3.tx_busy, if3.tx_done, cells[k/12]); end
         sync3 = ((k + 1) % 3 == 0);
         step();
      end
      checks++;
      if (if3.tx_done !== 1'b1 || if3.tx_ready !== 1'b1 || if3.tx_busy !== 1'b0 || line3 !== 1'b1)
         begin errors++; $display("FAIL frame_7n2_end: done=%b ready=%b busy=%b line=%b, want 1 1 0 1",
                                  if3.tx_done, if3.tx_ready, if3.tx_busy, line3); end
      sync3 = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic [9:0] a_cells, b_cells;
      a_cells = 10'b1000100100;
      b_cells = 10'b1001101000;
      if0.tx_data  = 8'h12;
      if0.tx_valid = 1'b1;
      step();
      if0.tx_data = 8'h34;
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (line0 !== a_cells[k/2] || if0.tx_busy !== 1'b1)
            begin errors++; $display("FAIL b2b_first cycle %0d: line=%b busy=%b, want line=%b busy=1",
                                     k, line0, if0.tx_busy, a_cells[k/2]); end
         step();
      end
      checks++;
      if (if0.tx_done !== 1'b1 || if0.tx_ready !== 1'b1 || line0 !== 1'b1)
         begin errors++; $display("FAIL b2b_done: done=%b ready=%b line=%b, want 1 1 1",
                                  if0.tx_done, if0.tx_ready, line0); end
      step();
      if0.tx_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (line0 !== b_cells[k/2] || if0.tx_busy !== 1'b1 || if0.tx_done !== 1'b0)
            begin errors++; $display("FAIL b2b_second cycle %0d: line=%b busy=%b done=%b, want line=%b busy=1 done=0",
                                     k, line0, if0.tx_busy, if0.tx_done, b_cells[k/2]); end
         if (k == 4) begin if0.tx_valid = 1'b1; if0.tx_data = 8'hFF; end
         if (k == 5) if0.tx_valid = 1'b0;
         step();
      end
      checks++;
      if (if0.tx_done !== 1'b1 || line0 !== 1'b1)
         begin errors++; $display("FAIL b2b_second_end: done=%b line=%b, want 1 1", if0.tx_done, line0); end
      step();
      checks++;
      if (if0.tx_busy !== 1'b0 || line0 !== 1'b1)
         begin errors++; $display("FAIL b2b_no_extra_frame: busy=%b line=%b, want 0 1", if0.tx_busy, line0); end
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] zero_cells;
      logic       saw_done;
      zero_cells = 10'b1000000000;
      if0.tx_data  = 8'hFF;
      if0.tx_valid = 1'b1;
      step();
      if0.tx_valid = 1'b0;
      for (int k = 0; k < 8; k++) step();
      checks++;
      if (line0 !== 1'b1 || if0.tx_busy !== 1'b1)
         begin errors++; $display("FAIL rst_before: line=%b busy=%b, want 1 1", line0, if0.tx_busy); end
      rst = 1'b1;
      step();
      checks++;
      if (line0 !== 1'b1 || if0.tx_busy !== 1'b0 || if0.tx_ready !== 1'b1 || if0.tx_done !== 1'b0)
         begin errors++; $display("FAIL rst_mid_frame: line=%b busy=%b ready=%b done=%b, want 1 0 1 0",
                                  line0, if0.tx_busy, if0.tx_ready, if0.tx_done); end
      rst = 1'b0;
      saw_done = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (if0.tx_done !== 1'b0 || line0 !== 1'b1) saw_done = 1'b1;
         step();
      end
      checks++;
      if (saw_done !== 1'b0)
         begin errors++; $display("FAIL rst_abandon: activity after reset=%b, want 0", saw_done); end
      if0.tx_data  = 8'h00;
      if0.tx_valid = 1'b1;
      step();
      if0.tx_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (line0 !== zero_cells[k/2])
            begin errors++; $display("FAIL rst_refill cycle %0d: line=%b, want %b", k, line0, zero_cells[k/2]); end
         step();
      end
      checks++;
      if (if0.tx_done !== 1'b1)
         begin errors++; $display("FAIL rst_refill_end: done=%b, want 1", if0.tx_done); end
      step();
   endtask

   task automatic test_tpb1_pause();
      logic [9:0] cells;
      int         c;
      logic       on;
      cells = 10'b1101001010;
      c = 0;
      sync4 = 1'b1;
      if4.tx_data  = 8'hA5;
      if4.tx_valid = 1'b1;
      step();
      if4.tx_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (line4 !== cells[c] || if4.tx_busy !== 1'b1 || if4.tx_done !== 1'b0)
            begin errors++; $display("FAIL tpb1_pause cycle %0d: line=%b busy=%b done=%b, want line=%b busy=1 done=0",
                                     k, line4, if4.tx_busy, if4.tx_done, cells[c]); end
         on = !((k + 1) >= 4 && (k + 1) <= 13);
         sync4 = on;
         step();
         if (on) c++;
      end
      checks++;
      if (if4.tx_done !== 1'b1 || if4.tx_ready !== 1'b1 || line4 !== 1'b1)
         begin errors++; $display("FAIL tpb1_end: done=%b ready=%b line=%b, want 1 1 1",
                                  if4.tx_done, if4.tx_ready, line4); end
      sync4 = 1'b0;
      step();
   endtask

   initial begin
      rst   = 1'b1;
      sync0 = 1'b1;
      sync1 = 1'b1;
      sync3 = 1'b0;
      sync4 = 1'b0;
      if0.tx_valid = 1'b0; if0.tx_data = '0;
      if1.tx_valid = 1'b0; if1.tx_data = '0;
      if2.tx_valid = 1'b0; if2.tx_data = '0;
      if3.tx_valid = 1'b0; if3.tx_data = '0;
      if4.tx_valid = 1'b0; if4.tx_data = '0;
      test_reset();
      test_frame_8n1();
      test_parity();
      test_7bit_2stop();
      test_back_to_back();
      test_reset_mid_frame();
      test_tpb1_pause();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, the next generation of the fixed 8N1 transmitter. It serialises one word per frame onto `tx_out`, LSB first. Data width, oversampling ratio, parity mode and stop-bit count are set by parameters, and a ready/valid handshake replaces the level-sensitive start input. It sits between the host-side byte source (register bank or FIFO) and the pad, and is paced by the shared baud `sync` tick.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, legal 5..9.
- `TICKS_PER_BIT`, default 2: `sync` ticks per bit cell, legal 1..16.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even; 3 is illegal and flagged by an elaboration-time error.
- `STOP_BITS`, default 1: legal 1 or 2.
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `sync`  in  1: baud tick enable, one `clk` wide, arbitrary spacing.
- `tx_valid`  in  1: `tx_data` holds a word to send.
- `tx_data`  in  `DATA_BITS`: payload.
- `tx_ready`  out  1: block can accept a word (IDLE only).
- `tx_out`  out  1: serial line, idle high.
- `tx_busy`  out  1: a frame is in progress.
- `tx_done`  out  1: one-cycle pulse at the end of a frame.

## Operation
- Reset values: `tx_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0; state IDLE; tick and bit counters 0; shift register 0.
- **Accept.** A word is accepted on any `clk` edge where `tx_valid & tx_ready` is true; `sync` is not required. On that edge:
  - `tx_data` is latched into the shift register.
  - Parity bit is computed: even = XOR of data; odd = its inverse.
  - State goes to START, `tx_out` goes to 0, `tx_ready` goes to 0, `tx_busy` goes to 1.
- **States and transitions.** IDLE -> START -> DATA -> PARITY (only if `PARITY`≠0) -> STOP -> IDLE.
- **Bit cells.**
  - The tick counter increments on each `sync` while not IDLE.
  - When it reaches `TICKS_PER_BIT-1` and `sync`=1, the cell ends: the counter clears, and `tx_out` and state advance on the same edge.
- **DATA.** Shifts out `DATA_BITS` bits, LSB first. The bit counter counts 0..`DATA_BITS-1`, and the last bit ends by moving to PARITY or STOP.
- **PARITY.** `tx_out` = latched parity bit for one cell.
- **STOP.** `tx_out`=1 for `STOP_BITS` cells.
- **End of frame.** At the end of the last stop cell: state goes to IDLE, `tx_done` pulses high for exactly one cycle, `tx_busy` goes to 0, `tx_ready` goes to 1 on the same edge.
- **Simultaneous events.**
  - `tx_valid` held high while busy is ignored; `tx_data` may change freely after acceptance.
  - `sync` coincident with the accept edge does not count toward the start cell.
- **Reset mid-frame.** Returns to reset values on the next edge: `tx_out` snaps to 1, no `tx_done`, the frame is abandoned.
- **Width rules.**
  - Tick counter is `$clog2(TICKS_PER_BIT)`-wide, minimum 1 bit. With `TICKS_PER_BIT`=1 every `sync` ends a cell.
  - Bit counter is `$clog2(DATA_BITS)`-wide, minimum 1 bit.
  - No counter wraps except by explicit clear.

## Timing
- Accept edge to start-bit drive: `tx_out` low from the cycle after acceptance.
- Frame length in cells: 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`, each `TICKS_PER_BIT` `sync` ticks long.
- With `sync` tied high, frame length in `clk` cycles = cells × `TICKS_PER_BIT`.
- `tx_done` is asserted in the first cycle after the final stop cell ends.
- Back-to-back throughput: the next word may be accepted in the same cycle `tx_done` is high, so zero idle cells between frames.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package `uart_pkg` holds:
  - parity encodings `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - state enum `uart_tx_state_t` {IDLE, START, DATA, PARITY, STOP};
  - `parity_of()` function (the future receiver reuses it).
- Sub-module `uart_bit_timer`: `sync`-gated tick counter with `clear` input and `cell_end` output, parameter `TICKS_PER_BIT`; shared with the planned receiver.

## Test plan
- Default params (8N1, `TICKS_PER_BIT`=2), `sync`=1, send 0xA5 -> `tx_out` cells 0,1,0,1,0,0,1,0,1,1, each 2 cycles; `tx_done` pulse 20 cycles after the first low cycle; `tx_ready` back to 1 on the same edge.
- `PARITY`=2 then `PARITY`=1, send 0xA5 (four ones) -> parity cell 0 for even, 1 for odd; frame 11 cells.
- `DATA_BITS`=7, `STOP_BITS`=2, `TICKS_PER_BIT`=4, `sync` every 3rd cycle, send 0x41 -> 7 data cells 1,0,0,0,0,0,1 then 2 high cells; each cell 12 `clk` cycles long.
- `tx_valid` held high with words 0x12, 0x34 -> second word accepted on the `tx_done` cycle; no idle cell between frames; `tx_valid` pulsed during busy is not accepted.
- Assert `rst` during data bit 3 of 0xFF -> `tx_out`=1, `tx_busy`=0, `tx_ready`=1 next cycle, no `tx_done`; a subsequent 0x00 frame is transmitted correctly.
- `TICKS_PER_BIT`=1 with `sync` gated off for 10 cycles mid-frame -> line holds its current value and resumes exactly where it paused.
